// File: rtl/gray_rx_tracker.sv
// gray_rx_tracker
//   Consumer end of a Gray-coded count link. Each Valid sample is decoded to
//   binary and checked against the last accepted value. Only a repeat (stall)
//   or a +1 step (modulo 2^WIDTH) is legal. Every max->0 step counts as a wrap.
//   Any other step latches Error and drops lock until Resync or Reset.
//
// Ports
//   Clk        in   rising-edge clock
//   Reset      in   synchronous, active-high; clears all state
//   Valid      in   GrayIn is sampled on this cycle
//   GrayIn     in   [WIDTH-1:0] Gray-coded count from the transmitter
//   Resync     in   drop lock and re-acquire on the next Valid
//   Binary     out  [WIDTH-1:0] decoded value of the last accepted sample
//   Locked     out  a reference value is held and steps are being checked
//   Wrap       out  one-cycle pulse on an accepted max->0 step
//   Overflow   out  sticky, set on the first wrap
//   WrapCount  out  [CNT_W-1:0] number of wraps, saturating
//   Error      out  sticky, set on any illegal step
module gray_rx_tracker #(
  parameter int WIDTH = 3,
  parameter int CNT_W = 8
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Valid,
  input  logic [WIDTH-1:0] GrayIn,
  input  logic             Resync,
  output logic [WIDTH-1:0] Binary,
  output logic             Locked,
  output logic             Wrap,
  output logic             Overflow,
  output logic [CNT_W-1:0] WrapCount,
  output logic             Error
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_TRACK = 2'd1,
    ST_FAULT = 2'd2
  } state_e;

  // Gray to binary: each binary bit is the XOR of all Gray bits at or above it.
  function automatic logic [WIDTH-1:0] gray_to_bin(input logic [WIDTH-1:0] g);
    logic [WIDTH-1:0] b;
    b[WIDTH-1] = g[WIDTH-1];
    for (int i = WIDTH - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  state_e           state_q, state_d;
  logic [WIDTH-1:0] binary_q, binary_d;
  logic             locked_q, locked_d;
  logic             wrap_q, wrap_d;
  logic             overflow_q, overflow_d;
  logic [CNT_W-1:0] wrap_cnt_q, wrap_cnt_d;
  logic             error_q, error_d;

  logic [WIDTH-1:0] dec_s;
  logic [WIDTH-1:0] succ_s;
  logic             at_max_s;
  logic             cnt_sat_s;

  assign dec_s     = gray_to_bin(GrayIn);
  // Natural truncation to WIDTH bits gives the modulo-2^WIDTH successor.
  assign succ_s    = binary_q + WIDTH'(1'b1);
  assign at_max_s  = (binary_q == {WIDTH{1'b1}});
  assign cnt_sat_s = (wrap_cnt_q == {CNT_W{1'b1}});

  // Next-state and next-output logic for the tracking FSM.
  always_comb begin
    state_d    = state_q;
    binary_d   = binary_q;
    locked_d   = locked_q;
    wrap_d     = 1'b0;
    overflow_d = overflow_q;
    wrap_cnt_d = wrap_cnt_q;
    error_d    = error_q;

    if (Resync) begin
      // Sticky flags and Binary survive a resync; any sample this cycle is dropped.
      state_d  = ST_IDLE;
      locked_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (Valid) begin
            // First sample only establishes the reference: no step check, no wrap.
            binary_d = dec_s;
            locked_d = 1'b1;
            state_d  = ST_TRACK;
          end else begin
            state_d = ST_IDLE;
          end
        end

        ST_TRACK: begin
          if (Valid) begin
            if (dec_s == binary_q) begin
              // Stall: transmitter has not advanced yet.
              state_d = ST_TRACK;
            end else if (dec_s == succ_s) begin
              binary_d = dec_s;
              if (at_max_s) begin
                wrap_d     = 1'b1;
                overflow_d = 1'b1;
                if (!cnt_sat_s) begin
                  wrap_cnt_d = wrap_cnt_q + CNT_W'(1'b1);
                end else begin
                  wrap_cnt_d = wrap_cnt_q;
                end
              end else begin
                wrap_d = 1'b0;
              end
            end else begin
              // Skip, backward or multi-bit change: keep the last good value.
              error_d  = 1'b1;
              locked_d = 1'b0;
              state_d  = ST_FAULT;
            end
          end else begin
            state_d = ST_TRACK;
          end
        end

        ST_FAULT: begin
          locked_d = 1'b0;
          state_d  = ST_FAULT;
        end

        default: begin
          state_d  = ST_IDLE;
          locked_d = 1'b0;
        end
      endcase
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q    <= ST_IDLE;
      binary_q   <= {WIDTH{1'b0}};
      locked_q   <= 1'b0;
      wrap_q     <= 1'b0;
      overflow_q <= 1'b0;
      wrap_cnt_q <= {CNT_W{1'b0}};
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      binary_q   <= binary_d;
      locked_q   <= locked_d;
      wrap_q     <= wrap_d;
      overflow_q <= overflow_d;
      wrap_cnt_q <= wrap_cnt_d;
      error_q    <= error_d;
    end
  end

  assign Binary    = binary_q;
  assign Locked    = locked_q;
  assign Wrap      = wrap_q;
  assign Overflow  = overflow_q;
  assign WrapCount = wrap_cnt_q;
  assign Error     = error_q;

endmodule

// File: tb/tb_gray_rx_tracker.sv
// Self-checking bench for gray_rx_tracker. Two instances share the stimulus:
// one with the default 8-bit wrap counter and one with a 2-bit counter so
// that saturation is reached quickly. A behavioural model tracks the count as
// plain integers and predicts every output after each clock.
module tb_gray_rx_tracker;

  logic       Clk = 1'b0;
  logic       Reset;
  logic       Valid;
  logic       Resync;
  logic [2:0] GrayIn;

  logic [2:0] bin_a, bin_b;
  logic       lck_a, lck_b, wrp_a, wrp_b, ovf_a, ovf_b, err_a, err_b;
  logic [7:0] cnt_a;
  logic [1:0] cnt_b;

  int n_vec  = 0;
  int n_fail = 0;

  // Reference model state
  bit m_has_ref;
  bit m_fault;
  int m_bin;
  bit m_wrap;
  bit m_ovf;
  bit m_err;
  int m_wraps;

  always #5 Clk = ~Clk;

  gray_rx_tracker #(.WIDTH(3), .CNT_W(8)) dut (
    .Clk(Clk), .Reset(Reset), .Valid(Valid), .GrayIn(GrayIn), .Resync(Resync),
    .Binary(bin_a), .Locked(lck_a), .Wrap(wrp_a), .Overflow(ovf_a),
    .WrapCount(cnt_a), .Error(err_a)
  );

  gray_rx_tracker #(.WIDTH(3), .CNT_W(2)) dut_sat (
    .Clk(Clk), .Reset(Reset), .Valid(Valid), .GrayIn(GrayIn), .Resync(Resync),
    .Binary(bin_b), .Locked(lck_b), .Wrap(wrp_b), .Overflow(ovf_b),
    .WrapCount(cnt_b), .Error(err_b)
  );

  function automatic int to_gray(input int b);
    return (b ^ (b >> 1)) & 7;
  endfunction

  // Decode by searching for the count whose Gray code matches.
  function automatic int from_gray(input int g);
    for (int v = 0; v < 8; v++) begin
      if (to_gray(v) == g) return v;
    end
    return -1;
  endfunction

  function automatic int min_int(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  task automatic chk(input string tag, input int obs, input int exp);
    n_vec++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_update(input bit rst, input bit v, input bit rs, input int g);
    int d;
    d = from_gray(g);
    m_wrap = 1'b0;
    if (rst) begin
      m_has_ref = 0; m_fault = 0; m_bin = 0; m_ovf = 0; m_err = 0; m_wraps = 0;
    end else if (rs) begin
      m_has_ref = 0; m_fault = 0;
    end else if (v && !m_fault) begin
      if (!m_has_ref) begin
        m_has_ref = 1;
        m_bin = d;
      end else if (d == m_bin) begin
        m_bin = d;
      end else if (d == (m_bin + 1) % 8) begin
        if (d == 0) begin
          m_wrap = 1'b1;
          m_ovf = 1'b1;
          m_wraps++;
        end
        m_bin = d;
      end else begin
        m_err = 1'b1;
        m_fault = 1;
      end
    end
  endtask

  task automatic check_all();
    bit lk;
    lk = m_has_ref && !m_fault;
    chk("binary",     bin_a, m_bin);
    chk("locked",     lck_a, lk);
    chk("wrap",       wrp_a, m_wrap);
    chk("overflow",   ovf_a, m_ovf);
    chk("wrapcount",  cnt_a, min_int(m_wraps, 255));
    chk("error",      err_a, m_err);
    chk("sat_binary", bin_b, m_bin);
    chk("sat_locked", lck_b, lk);
    chk("sat_wrap",   wrp_b, m_wrap);
    chk("sat_count",  cnt_b, min_int(m_wraps, 3));
    chk("sat_error",  err_b, m_err);
  endtask

  task automatic step(input bit rst, input bit v, input bit rs, input int g);
    Reset = rst; Valid = v; Resync = rs; GrayIn = 3'(g);
    @(posedge Clk);
    #1;
    model_update(rst, v, rs, g);
    check_all();
  endtask

  initial begin
    int seq[9];
    int r;
    seq = '{0, 1, 3, 2, 6, 7, 5, 4, 0};
    Reset = 1'b1; Valid = 1'b0; Resync = 1'b0; GrayIn = 3'd0;
    m_has_ref = 0; m_fault = 0; m_bin = 0; m_wrap = 0; m_ovf = 0; m_err = 0; m_wraps = 0;

    // Reset state
    step(1, 1, 0, 5);
    chk("rst_binary", bin_a, 0);
    chk("rst_locked", lck_a, 0);

    // Full sequence 0..7,0
    step(0, 0, 0, 0);
    for (int i = 0; i < 9; i++) begin
      step(0, 1, 0, seq[i]);
      chk("seq_binary", bin_a, i % 8);
    end
    chk("seq_wrap", wrp_a, 1);
    step(0, 0, 0, 0);
    chk("seq_wrap_clr", wrp_a, 0);
    chk("seq_ovf", ovf_a, 1);
    chk("seq_cnt", cnt_a, 1);
    chk("seq_lock", lck_a, 1);

    // First-sample acquire and stall
    step(1, 0, 0, 0);
    step(0, 1, 0, 3'b110);
    chk("acq_binary", bin_a, 4);
    step(0, 1, 0, 3'b110);
    step(0, 1, 0, 3'b110);
    step(0, 0, 0, 3'b011);
    chk("stall_binary", bin_a, 4);
    chk("stall_err", err_a, 0);

    // Skip error, then resync
    step(1, 0, 0, 0);
    step(0, 1, 0, 3'b000);
    step(0, 1, 0, 3'b001);
    step(0, 1, 0, 3'b010);
    chk("skip_err", err_a, 1);
    chk("skip_lock", lck_a, 0);
    chk("skip_bin", bin_a, 1);
    step(0, 1, 0, 3'b110);
    chk("fault_bin", bin_a, 1);
    step(0, 1, 1, 3'b011);
    step(0, 1, 0, 3'b101);
    chk("resync_bin", bin_a, 6);
    chk("resync_lock", lck_a, 1);
    step(0, 1, 0, 3'b100);
    chk("resync_bin2", bin_a, 7);
    chk("resync_err", err_a, 1);

    // Backward single-bit Gray step
    step(1, 0, 0, 0);
    step(0, 1, 0, 3'b011);
    step(0, 1, 0, 3'b001);
    chk("back_err", err_a, 1);
    chk("back_bin", bin_a, 2);

    // Long clean run: saturate both wrap counters
    step(1, 0, 0, 0);
    for (int i = 0; i < 8 * 258 + 1; i++) begin
      step(0, 1, 0, to_gray(i % 8));
    end
    chk("sat_a", cnt_a, 255);
    chk("sat_b", cnt_b, 3);
    // Reset mid-sequence with Valid high, then a non-successor is accepted
    step(1, 1, 0, to_gray(3));
    chk("midrst_cnt", cnt_a, 0);
    step(0, 1, 0, to_gray(5));
    chk("midrst_acq", bin_a, 5);

    // Randomized traffic, biased towards legal steps
    for (int i = 0; i < 4000; i++) begin
      int g;
      bit v, rs, rst;
      r   = int'($urandom_range(0, 99));
      rst = (r < 1);
      rs  = (r >= 1 && r < 5);
      v   = ($urandom_range(0, 9) < 8);
      r   = int'($urandom_range(0, 99));
      if (r < 70)      g = to_gray((m_bin + 1) % 8);
      else if (r < 85) g = to_gray(m_bin);
      else             g = int'($urandom_range(0, 7));
      // Re-acquire quickly after faults so wraps keep accumulating
      if (m_fault && $urandom_range(0, 3) == 0) rs = 1;
      step(rst, v, rs, g);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/gray_rx_tracker.md
Name: gray_rx_tracker

Overview:
- Receive-side counterpart of the team's Gray-code counter: samples a Gray-coded count bus and converts it back to binary.
- Verifies that each new sample is the legal single-step successor of the previous one, and detects and counts wrap-around.
- Sits at the consumer end of a Gray-coded pointer/count link, for example a clock-domain crossing or a status monitor, and flags any corrupted or skipped step.

Parameters:
- WIDTH, 3, width of Gray input and binary output.
- CNT_W, 8, width of saturating wrap counter.

Ports:
- Clk  input  1  clock, rising edge.
- Reset  input  1  synchronous, active-high reset.
- Valid  input  1  GrayIn is sampled on this cycle.
- GrayIn  input  WIDTH  Gray-coded count from transmitter.
- Resync  input  1  drop lock and re-acquire on the next Valid.
- Binary  output  WIDTH  registered decoded value of last accepted sample.
- Locked  output  1  tracker has a reference value and is checking steps.
- Wrap  output  1  one-cycle pulse when an accepted step goes from max to 0.
- Overflow  output  1  sticky; set on first wrap.
- WrapCount  output  CNT_W  number of wraps, saturating at 2^CNT_W-1.
- Error  output  1  sticky; set on any illegal step.

Behaviour:
- Reset: reset is Reset, synchronous, active-high; clock is Clk. Reset has priority over everything and returns state to IDLE, with Binary=0, Locked=0, Wrap=0, Overflow=0, WrapCount=0, Error=0.
- Decode (combinational, internal): dec[WIDTH-1]=GrayIn[WIDTH-1]; dec[i]=dec[i+1]^GrayIn[i] for i from WIDTH-2 down to 0.
- Registering and latency: all outputs are registered. Latency is 1 cycle from a Valid sample to the Binary/flag update.
- Wrap pulse: Wrap defaults to 0 every cycle unless set as described below.
- States: IDLE, TRACK, FAULT.
- IDLE:
  - Valid=1: Binary<=dec, Locked<=1, go to TRACK. No step check on the first sample, and no wrap is counted.
  - Valid=0: hold.
- TRACK, on Valid=1:
  - dec==Binary (repeat/stall): no change, not an error.
  - dec==(Binary+1) mod 2^WIDTH: Binary<=dec.
    - If Binary was 2^WIDTH-1 (so dec==0): Wrap<=1, Overflow<=1, and WrapCount<=WrapCount+1 unless saturated.
  - Anything else: Error<=1, Locked<=0, Binary holds the last good value, go to FAULT. This covers multi-bit changes, skips and backward steps, including a single-bit backward Gray change.
- TRACK, on Valid=0: hold all values.
- FAULT: ignores Valid and holds all outputs; Locked=0.
- Resync=1 (any state, Reset not asserted):
  - Go to IDLE with Locked<=0 on the same edge. Any Valid sample in that cycle is ignored.
  - Error, Overflow and WrapCount are not cleared by Resync; only Reset clears them.
  - Binary holds until the next accepted sample.
- Arithmetic: successor compare is modulo 2^WIDTH. WrapCount saturates and never rolls over.
- Reset mid-operation: takes effect on that edge regardless of Valid/Resync; the next Valid is treated as a first sample.

Test Plan:
- Full sequence, WIDTH=3:
  - Stimulus: Reset, then Valid each cycle with GrayIn 000,001,011,010,110,111,101,100,000.
  - Response: Binary follows 0,1,2,3,4,5,6,7,0 one cycle after each sample. Wrap=1 for exactly one cycle after the final 000, then Overflow=1, WrapCount=1, Error=0, Locked=1.
- First-sample acquire and stall:
  - Stimulus: after Reset, GrayIn=110 Valid; then 110 Valid twice; then Valid=0 with GrayIn=011.
  - Response: Binary=4, Locked=1 with no Error. Repeats leave Binary=4. Binary is unchanged while Valid=0.
- Skip error:
  - Stimulus: 000, 001, 010 (binary 0,1,3).
  - Response: after 010, Error=1, Locked=0, Binary stays 1. A further Valid 110 leaves Binary=1.
- Backward step:
  - Stimulus: 011 then 001 (2 then 1, a single Gray bit change).
  - Response: Error=1, Locked=0, Binary=2.
- Resync after fault:
  - Stimulus: from the skip-error state, Resync=1 for one cycle, then Valid 101, then 100.
  - Response: Locked=1, Binary=6 then 7. Error remains 1.
- Saturation and reset mid-run:
  - Stimulus: CNT_W=2; run 4 full wraps, then assert Reset while Valid=1 mid-sequence.
  - Response: WrapCount is 3 after both the third and fourth wraps. On the Reset edge all outputs are 0 and the state is IDLE; the next Valid sample is accepted without a step check.
